// File: rtl/user_irq_router_pkg.sv
// Shared types and constants for the user-project interrupt router.
// Build option: IRQ_SYNC_EN selects 2-flop input synchronizers.
package user_irq_router_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GUARD  = 1'b1
    } rtr_state_t;

    localparam int GUARD_CNT_W = 8;

endpackage

// File: rtl/irq_sample_stage.sv
// Input sampling stage: one register, or a 2-flop synchronizer when
// IRQ_SYNC_EN is defined (projects on clocks unrelated to ALCLK).
module irq_sample_stage #(
    parameter int pWIDTH = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [pWIDTH-1:0] d_i,
    output logic [pWIDTH-1:0] q_o
);

    logic [pWIDTH-1:0] samp_q;

`ifdef IRQ_SYNC_EN
    logic [pWIDTH-1:0] meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            samp_q <= '0;
        end else begin
            meta_q <= d_i;
            samp_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q <= '0;
        end else begin
            samp_q <= d_i;
        end
    end
`endif

    assign q_o = samp_q;

endmodule

// File: rtl/user_irq_router.sv
// Routes one user project's hi-pri request and IRQ vector to the host,
// with a guarded switch sequence. Build option: IRQ_SYNC_EN.
module user_irq_router
    import user_irq_router_pkg::*;
#(
    parameter int         pNUM_PRJ       = 4,
    parameter int         pIRQ_WIDTH     = 1,
    parameter int         pGUARD_CYC     = 4,
    parameter logic [7:0] pIRQ_EDGE_MASK = 8'b0,
    localparam int        SEL_W          = $clog2(pNUM_PRJ)
) (
    input  logic                           ALCLK,
    input  logic                           ARESET,
    input  logic [SEL_W-1:0]               USER_PRJ_SEL,
    input  logic [pNUM_PRJ-1:0]            hi_pri_req_i,
    input  logic [pNUM_PRJ*pIRQ_WIDTH-1:0] user_irq_i,
    output logic                           hi_pri_req_o,
    output logic [pIRQ_WIDTH-1:0]          user_irq_o,
    output logic [SEL_W-1:0]               sel_active,
    output logic                           switching
);

    localparam int IRQ_BITS = pNUM_PRJ * pIRQ_WIDTH;
    localparam int NB       = pNUM_PRJ + IRQ_BITS;
    localparam logic [GUARD_CNT_W-1:0] RELOAD = GUARD_CNT_W'(pGUARD_CYC - 1);
    localparam logic [pIRQ_WIDTH-1:0]  EDGE_M = pIRQ_EDGE_MASK[pIRQ_WIDTH-1:0];

    logic [NB-1:0]                samp;
    logic [pNUM_PRJ-1:0]          hi_samp;
    logic [IRQ_BITS-1:0]          irq_samp;
    logic [IRQ_BITS-1:0]          prev_q;
    logic [SEL_W-1:0]             sel_req_q;
    rtr_state_t                   state_q, state_d;
    logic [SEL_W-1:0]             target_q, target_d;
    logic [SEL_W-1:0]             sel_active_q, sel_active_d;
    logic [GUARD_CNT_W-1:0]       cnt_q, cnt_d;
    logic                         hi_o_q, hi_o_d;
    logic [pIRQ_WIDTH-1:0]        irq_o_q, irq_o_d;
    logic                         req_ok;
    logic                         hi_sel;
    logic [pIRQ_WIDTH-1:0]        irq_sel, prev_sel;

    irq_sample_stage #(
        .pWIDTH (NB)
    ) u_samp (
        .clk_i (ALCLK),
        .rst_i (ARESET),
        .d_i   ({user_irq_i, hi_pri_req_i}),
        .q_o   (samp)
    );

    assign hi_samp  = samp[pNUM_PRJ-1:0];
    assign irq_samp = samp[NB-1:pNUM_PRJ];
    assign req_ok   = {1'b0, sel_req_q} < (SEL_W+1)'(pNUM_PRJ);

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        sel_active_d = sel_active_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (req_ok && sel_req_q != sel_active_q) begin
                    state_d  = ST_GUARD;
                    target_d = sel_req_q;
                    cnt_d    = RELOAD;
                end
            end
            ST_GUARD: begin
                // Any new target restarts the full guard, even the old one
                if (req_ok && sel_req_q != target_q) begin
                    target_d = sel_req_q;
                    cnt_d    = RELOAD;
                end else if (cnt_q == '0) begin
                    sel_active_d = target_q;
                    state_d      = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - GUARD_CNT_W'(1);
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        hi_sel   = 1'b0;
        irq_sel  = '0;
        prev_sel = '0;
        for (int p = 0; p < pNUM_PRJ; p++) begin
            if (sel_active_d == SEL_W'(p)) begin
                hi_sel   = hi_samp[p];
                irq_sel  = irq_samp[p*pIRQ_WIDTH +: pIRQ_WIDTH];
                prev_sel = prev_q[p*pIRQ_WIDTH +: pIRQ_WIDTH];
            end
        end
    end

    // Outputs are forced low for exactly as long as switching is high
    always_comb begin
        hi_o_d  = 1'b0;
        irq_o_d = '0;
        if (state_d == ST_ACTIVE) begin
            hi_o_d  = hi_sel;
            irq_o_d = irq_sel & ~(prev_sel & EDGE_M);
        end
    end

    always_ff @(posedge ALCLK or posedge ARESET) begin
        if (ARESET) begin
            prev_q       <= '0;
            sel_req_q    <= '0;
            state_q      <= ST_ACTIVE;
            target_q     <= '0;
            sel_active_q <= '0;
            cnt_q        <= '0;
            hi_o_q       <= 1'b0;
            irq_o_q      <= '0;
        end else begin
            prev_q       <= irq_samp;
            sel_req_q    <= USER_PRJ_SEL;
            state_q      <= state_d;
            target_q     <= target_d;
            sel_active_q <= sel_active_d;
            cnt_q        <= cnt_d;
            hi_o_q       <= hi_o_d;
            irq_o_q      <= irq_o_d;
        end
    end

    assign hi_pri_req_o = hi_o_q;
    assign user_irq_o   = irq_o_q;
    assign sel_active   = sel_active_q;
    assign switching    = (state_q == ST_GUARD);

endmodule

// File: tb/tb_user_irq_router.sv
// Directed bench for user_irq_router: 4-project edge-bit instance
// plus a 3-project instance for the invalid-select case.
module tb_user_irq_router;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [3:0] hi_i;
    logic [3:0] irq_i;
    logic       hi_o;
    logic [0:0] irq_o;
    logic [1:0] sel_act;
    logic       sw;

    logic [1:0] sel3;
    logic       hi_o3;
    logic [0:0] irq_o3;
    logic [1:0] sel_act3;
    logic       sw3;

    int n_chk;
    int n_fail;
    int np;

    user_irq_router #(
        .pNUM_PRJ       (4),
        .pIRQ_WIDTH     (1),
        .pGUARD_CYC     (4),
        .pIRQ_EDGE_MASK (8'h01)
    ) u_dut (
        .ALCLK        (clk),
        .ARESET       (rst),
        .USER_PRJ_SEL (sel),
        .hi_pri_req_i (hi_i),
        .user_irq_i   (irq_i),
        .hi_pri_req_o (hi_o),
        .user_irq_o   (irq_o),
        .sel_active   (sel_act),
        .switching    (sw)
    );

    user_irq_router #(
        .pNUM_PRJ       (3),
        .pIRQ_WIDTH     (1),
        .pGUARD_CYC     (4),
        .pIRQ_EDGE_MASK (8'h00)
    ) u_dut3 (
        .ALCLK        (clk),
        .ARESET       (rst),
        .USER_PRJ_SEL (sel3),
        .hi_pri_req_i (3'b000),
        .user_irq_i   (3'b000),
        .hi_pri_req_o (hi_o3),
        .user_irq_o   (irq_o3),
        .sel_active   (sel_act3),
        .switching    (sw3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        sel    = 2'd0;
        sel3   = 2'd0;
        hi_i   = 4'h0;
        irq_i  = 4'h0;

        // reset held with inputs toggling
        for (int i = 0; i < 5; i++) begin
            hi_i  = 4'(i * 5 + 3);
            irq_i = 4'(i * 3 + 5);
            tick();
            chk("rst_hi", hi_o, 0);
            chk("rst_irq", irq_o, 0);
        end
        hi_i  = 4'h0;
        irq_i = 4'h0;
        rst   = 1'b0;
        tick();
        chk("post_rst_hi", hi_o, 0);
        chk("post_rst_irq", irq_o, 0);
        chk("post_rst_sel", sel_act, 0);
        chk("post_rst_sw", sw, 0);

        // latency
        hi_i = 4'b0001;
        repeat (LAT - 1) tick();
        chk("lat_early", hi_o, 0);
        tick();
        chk("lat_hi", hi_o, 1);

        // other project's request is not routed
        hi_i = 4'b0010;
        repeat (LAT + 1) tick();
        chk("p1_hi_blocked", hi_o, 0);
        hi_i = 4'b0000;
        repeat (LAT) tick();

        // edge bit: one pulse for a 10-cycle high
        irq_i = 4'b0001;
        repeat (LAT - 1) tick();
        chk("edge_early", irq_o, 0);
        tick();
        chk("edge_pulse", irq_o, 1);
        np = 0;
        repeat (9) begin
            tick();
            np += int'(irq_o);
        end
        chk("edge_once", np, 0);

        // switch 0 -> 2
        hi_i  = 4'b0101;
        irq_i = 4'b0010;
        repeat (LAT) tick();
        chk("pre_sw_hi", hi_o, 1);
        sel = 2'd2;
        tick();
        chk("sw_req_reg", sw, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("guard_sw", sw, 1);
            chk("guard_hi0", hi_o, 0);
        end
        tick();
        chk("sw2_done", sw, 0);
        chk("sw2_sel", sel_act, 2);
        chk("sw2_hi", hi_o, 1);

        // retarget mid-guard at cnt=1
        hi_i = 4'b1000;
        sel  = 2'd0;
        repeat (4) tick();
        chk("rt_in_guard", sw, 1);
        sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rt_guard", sw, 1);
            chk("rt_sel_hold", sel_act, 2);
        end
        tick();
        chk("rt_done", sw, 0);
        chk("rt_sel3", sel_act, 3);
        chk("rt_hi3", hi_o, 1);

        // project 1 already high at switch-in: no pulse
        sel = 2'd1;
        np  = 0;
        repeat (6) begin
            tick();
            np += int'(irq_o);
        end
        chk("sw1_sel", sel_act, 1);
        repeat (4) begin
            tick();
            np += int'(irq_o);
        end
        chk("sw1_no_pulse", np, 0);
        chk("sw1_hi", hi_o, 0);
        irq_i = 4'b0000;
        repeat (LAT + 1) tick();
        irq_i = 4'b0010;
        repeat (LAT - 1) tick();
        chk("p1_edge_early", irq_o, 0);
        tick();
        chk("p1_edge", irq_o, 1);
        tick();
        chk("p1_edge_end", irq_o, 0);

        // reset mid-guard with pending select
        sel = 2'd2;
        tick();
        tick();
        chk("mg_guard", sw, 1);
        rst = 1'b1;
        #1;
        chk("mg_rst_sel", sel_act, 0);
        chk("mg_rst_sw", sw, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mg_req_reg", sw, 0);
        tick();
        chk("mg_reguard", sw, 1);
        repeat (4) tick();
        chk("mg_sel2", sel_act, 2);
        chk("mg_done", sw, 0);

        // invalid select on 3-project instance
        sel3 = 2'd3;
        repeat (8) begin
            tick();
            chk("inv_sw", sw3, 0);
        end
        chk("inv_sel", sel_act3, 0);
        sel3 = 2'd2;
        tick();
        tick();
        chk("v3_guard", sw3, 1);
        repeat (4) tick();
        chk("v3_sel2", sel_act3, 2);
        sel3 = 2'd3;
        repeat (8) tick();
        chk("inv2_sel", sel_act3, 2);
        chk("inv2_sw", sw3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
